integrator_step_ctrl: RTL and testbench

INTEGRATOR_STEP_CTRL -- requirements
Module: integrator_step_ctrl

---
 rtl/integrator_pkg.sv | 16 +
 rtl/step_divider.sv | 25 ++
 rtl/integrator_step_ctrl.sv | 142 ++++++++++++++
 tb/tb_integrator_step_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/integrator_pkg.sv
// Shared widths and FSM state encoding for the integrator step controller.
package integrator_pkg;

  localparam int unsigned DATA_W     = 27;
  localparam int unsigned DIV_W      = 5;
  localparam int unsigned STEP_CNT_W = 32;
  localparam int unsigned DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_STEP
  } state_t;

endpackage

// File: rtl/step_divider.sv
// Programmable step divider: ticks once every (period + 1) enabled cycles.
module step_divider #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  assign tick = en && (count == period);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/integrator_step_ctrl.sv
// Integrator step controller: loads initial conditions, paces integration steps
// from a programmable divider and captures post-step state snapshots.
module integrator_step_ctrl #(
  parameter int unsigned DATA_W  = integrator_pkg::DATA_W,
  parameter int unsigned DIV_W   = integrator_pkg::DIV_W,
  parameter int unsigned CAP_LAT = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic                                   single_step,
  input  logic        [DIV_W-1:0]                div_val,
  input  logic signed [DATA_W-1:0]               init_x,
  input  logic signed [DATA_W-1:0]               init_y,
  input  logic signed [DATA_W-1:0]               init_z,
  input  logic signed [DATA_W-1:0]               int_x,
  input  logic signed [DATA_W-1:0]               int_y,
  input  logic signed [DATA_W-1:0]               int_z,
  output logic                                   int_load,
  output logic signed [DATA_W-1:0]               int_x0,
  output logic signed [DATA_W-1:0]               int_y0,
  output logic signed [DATA_W-1:0]               int_z0,
  output logic                                   int_en,
  output logic signed [DATA_W-1:0]               snap_x,
  output logic signed [DATA_W-1:0]               snap_y,
  output logic signed [DATA_W-1:0]               snap_z,
  output logic                                   snap_valid,
  input  logic                                   snap_ready,
  output logic [integrator_pkg::STEP_CNT_W-1:0]  step_count,
  output logic [integrator_pkg::DROP_CNT_W-1:0]  drop_count,
  output logic                                   busy
);

  import integrator_pkg::*;

  state_t             state;
  state_t             state_next;
  logic               load_ic;
  logic [DIV_W-1:0]   div_latch;
  logic               div_tick;
  logic [CAP_LAT-1:0] cap_pipe;
  logic               cap_now;
  logic               cap_accept;

  step_divider #(
    .WIDTH(DIV_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_LOAD),
    .en    (state == ST_RUN),
    .period(div_latch),
    .tick  (div_tick)
  );

  // Bit CAP_LAT-1 of the delay line marks the cycle the integrator outputs are valid.
  assign cap_now    = cap_pipe[CAP_LAT-1];
  assign cap_accept = cap_now && (!snap_valid || snap_ready);
  assign busy       = (state != ST_IDLE) || (|cap_pipe);

  always_comb begin
    state_next = state;
    load_ic    = 1'b0;
    int_load   = 1'b0;
    int_en     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOAD;
          load_ic    = 1'b1;
        end else if (single_step) begin
          state_next = ST_STEP;
        end
      end
      ST_LOAD: begin
        int_load   = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else begin
          int_en = div_tick;
        end
      end
      ST_STEP: begin
        int_en     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      div_latch  <= '0;
      int_x0     <= '0;
      int_y0     <= '0;
      int_z0     <= '0;
      step_count <= '0;
    end else begin
      state <= state_next;
      if (load_ic) begin
        div_latch  <= div_val;
        int_x0     <= init_x;
        int_y0     <= init_y;
        int_z0     <= init_z;
        step_count <= '0;
      end else if (int_en) begin
        step_count <= step_count + STEP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_pipe   <= '0;
      snap_valid <= 1'b0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_z     <= '0;
      drop_count <= '0;
    end else begin
      cap_pipe <= (cap_pipe << 1) | CAP_LAT'(int_en);
      if (cap_accept) begin
        snap_x     <= int_x;
        snap_y     <= int_y;
        snap_z     <= int_z;
        snap_valid <= 1'b1;
      end else if (cap_now) begin
        if (drop_count != '1) begin
          drop_count <= drop_count + DROP_CNT_W'(1);
        end
      end else if (snap_valid && snap_ready) begin
        snap_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_integrator_step_ctrl.sv
// Scoreboard bench for integrator_step_ctrl: directed runs push expected events,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_integrator_step_ctrl;

  localparam int DATA_W  = 27;
  localparam int DIV_W   = 5;
  localparam int CAP_LAT = 1;

  logic clk = 1'b0;
  logic reset, start, stop, single_step, snap_ready;
  logic [DIV_W-1:0] div_val;
  logic signed [DATA_W-1:0] init_x, init_y, init_z;
  logic signed [DATA_W-1:0] int_x, int_y, int_z;
  logic signed [DATA_W-1:0] int_x0, int_y0, int_z0;
  logic signed [DATA_W-1:0] snap_x, snap_y, snap_z;
  logic int_load, int_en, snap_valid, busy;
  logic [31:0] step_count;
  logic [7:0]  drop_count;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    int                       cyc;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic signed [DATA_W-1:0] z;
  } ev_t;

  int  en_q[$];
  ev_t load_q[$];
  ev_t snap_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Integrator stand-in: outputs encode the current cycle so a snapshot reveals when it was taken.
  function automatic logic signed [DATA_W-1:0] fx(input int c);
    return DATA_W'(c);
  endfunction
  function automatic logic signed [DATA_W-1:0] fy(input int c);
    return DATA_W'(-3 * c);
  endfunction
  function automatic logic signed [DATA_W-1:0] fz(input int c);
    return DATA_W'(c * 1000 - 7);
  endfunction

  assign int_x = fx(cyc);
  assign int_y = fy(cyc);
  assign int_z = fz(cyc);

  integrator_step_ctrl #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W),
    .CAP_LAT(CAP_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .single_step(single_step),
    .div_val    (div_val),
    .init_x     (init_x),
    .init_y     (init_y),
    .init_z     (init_z),
    .int_x      (int_x),
    .int_y      (int_y),
    .int_z      (int_z),
    .int_load   (int_load),
    .int_x0     (int_x0),
    .int_y0     (int_y0),
    .int_z0     (int_z0),
    .int_en     (int_en),
    .snap_x     (snap_x),
    .snap_y     (snap_y),
    .snap_z     (snap_z),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .step_count (step_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_step(input int c, input bit captured);
    ev_t e;
    en_q.push_back(c);
    if (captured) begin
      e.cyc = c + CAP_LAT;
      e.x   = fx(c + CAP_LAT);
      e.y   = fy(c + CAP_LAT);
      e.z   = fz(c + CAP_LAT);
      snap_q.push_back(e);
    end
  endtask

  // Issues start (optionally with single_step) in IDLE and returns in the LOAD cycle.
  task automatic begin_run(input int div, input int x, input int y, input int z,
                           input bit with_step, output int s);
    ev_t e;
    goto(cyc + 1);
    s           = cyc;
    div_val     = DIV_W'(div);
    init_x      = DATA_W'(x);
    init_y      = DATA_W'(y);
    init_z      = DATA_W'(z);
    start       = 1'b1;
    single_step = with_step;
    e.cyc = s + 1;
    e.x   = DATA_W'(x);
    e.y   = DATA_W'(y);
    e.z   = DATA_W'(z);
    load_q.push_back(e);
    goto(s + 1);
    start       = 1'b0;
    single_step = 1'b0;
    init_x      = '0;
    init_y      = '0;
    init_z      = '0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_int_load"},   int_load,   0);
    check({tag, "_int_en"},     int_en,     0);
    check({tag, "_snap_valid"}, snap_valid, 0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_step_count"}, step_count, 0);
    check({tag, "_drop_count"}, drop_count, 0);
    check({tag, "_int_x0"},     int_x0,     0);
    check({tag, "_int_y0"},     int_y0,     0);
    check({tag, "_int_z0"},     int_z0,     0);
    check({tag, "_snap_x"},     snap_x,     0);
    check({tag, "_snap_y"},     snap_y,     0);
    check({tag, "_snap_z"},     snap_z,     0);
  endtask

  always @(negedge clk) begin : monitor
    int  c;
    ev_t e;
    if (int_en === 1'b1) begin
      if (en_q.size() == 0) check("unexpected_int_en", cyc, -1);
      else begin
        c = en_q.pop_front();
        check("int_en_cycle", cyc, c);
      end
    end
    if (int_load === 1'b1) begin
      if (load_q.size() == 0) check("unexpected_int_load", cyc, -1);
      else begin
        e = load_q.pop_front();
        check("int_load_cycle", cyc, e.cyc);
        check("int_x0", int_x0, e.x);
        check("int_y0", int_y0, e.y);
        check("int_z0", int_z0, e.z);
      end
    end
    if (snap_valid === 1'b1 && snap_ready === 1'b1) begin
      if (snap_q.size() == 0) check("unexpected_snapshot", cyc, -1);
      else begin
        e = snap_q.pop_front();
        check("snap_x", snap_x, e.x);
        check("snap_y", snap_y, e.y);
        check("snap_z", snap_z, e.z);
      end
    end
  end

  initial begin
    int s;
    int q;
    reset       = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    single_step = 1'b0;
    snap_ready  = 1'b1;
    div_val     = '0;
    init_x      = '0;
    init_y      = '0;
    init_z      = '0;
    goto(3);
    @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;

    // div_val=3: steps 4 cycles apart; a div_val change mid-run must not matter
    begin_run(3, 123, -456, 789, 1'b0, s);
    div_val = DIV_W'(7);
    expect_step(s + 5, 1'b1);
    expect_step(s + 9, 1'b1);
    expect_step(s + 13, 1'b1);
    goto(s + 14);
    stop = 1'b1;
    goto(s + 15);
    stop = 1'b0;
    @(negedge clk);
    check("div3_step_count", step_count, 3);
    check("div3_busy_idle", busy, 0);

    // div_val=0: int_en every RUN cycle, stop cuts the train
    begin_run(0, 1, 2, 3, 1'b0, s);
    for (int k = 0; k < 10; k++) expect_step(s + 2 + k, 1'b1);
    goto(s + 12);
    stop = 1'b1;
    goto(s + 13);
    stop = 1'b0;
    @(negedge clk);
    check("div0_step_count", step_count, 10);

    // stop coinciding with a divider match
    begin_run(3, 5, 6, 7, 1'b0, s);
    expect_step(s + 5, 1'b1);
    goto(s + 9);
    stop = 1'b1;
    @(negedge clk);
    check("stop_on_match_int_en", int_en, 0);
    goto(s + 10);
    stop = 1'b0;
    @(negedge clk);
    check("stop_on_match_idle", busy, 0);
    check("stop_on_match_step_count", step_count, 1);

    // backpressure: first sample held, later ones dropped
    snap_ready = 1'b0;
    begin_run(1, -8, 9, -10, 1'b0, s);
    expect_step(s + 3, 1'b1);
    expect_step(s + 5, 1'b0);
    expect_step(s + 7, 1'b0);
    expect_step(s + 9, 1'b0);
    goto(s + 10);
    stop = 1'b1;
    goto(s + 11);
    stop = 1'b0;
    @(negedge clk);
    check("bp_snap_valid_held", snap_valid, 1);
    check("bp_snap_x_held", snap_x, fx(s + 4));
    check("bp_drop_count", drop_count, 3);
    check("bp_step_count", step_count, 4);
    goto(s + 12);
    snap_ready = 1'b1;
    goto(s + 13);
    @(negedge clk);
    check("bp_snap_valid_cleared", snap_valid, 0);

    // start beats single_step; single_step ignored in RUN; one STEP from IDLE
    begin_run(3, 11, 12, 13, 1'b1, s);
    goto(s + 2);
    single_step = 1'b1;
    goto(s + 3);
    single_step = 1'b0;
    stop = 1'b1;
    goto(s + 4);
    stop = 1'b0;
    goto(s + 6);
    q = cyc;
    single_step = 1'b1;
    expect_step(q + 1, 1'b1);
    goto(q + 1);
    single_step = 1'b0;
    goto(q + 2);
    @(negedge clk);
    check("step_step_count", step_count, 1);
    check("step_busy_capture_pending", busy, 1);
    goto(q + 3);
    @(negedge clk);
    check("step_busy_done", busy, 0);

    // reset mid-RUN discards the pending capture
    begin_run(0, 21, 22, 23, 1'b0, s);
    expect_step(s + 2, 1'b0);
    expect_step(s + 3, 1'b0);
    goto(s + 3);
    reset = 1'b1;
    goto(s + 4);
    reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("midrun_reset");
    goto(s + 10);
    @(negedge clk);
    check("no_snap_after_reset", snap_valid, 0);

    check("en_queue_drained", en_q.size(), 0);
    check("load_queue_drained", load_q.size(), 0);
    check("snap_queue_drained", snap_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
